// File: rtl/vec_mem_pkg.sv
// vec_mem_pkg: shared defaults, word type and controller state encoding for the vector data memory
package vec_mem_pkg;
  localparam int LANES_D = 6;
  localparam int EW_D = 8;
  localparam int DEPTH_D = 10927;
  localparam int AW_D = 17;
  typedef logic [LANES_D-1:0][EW_D-1:0] vec_word_t;
  typedef enum logic {CLEAR, RUN} state_t;
endpackage

// File: rtl/vec_mem_array.sv
// vec_mem_array: word storage with one lane-masked write port and one registered read port
module vec_mem_array
  import vec_mem_pkg::*;
#(
  parameter int LANES = LANES_D,
  parameter int EW = EW_D,
  parameter int DEPTH = DEPTH_D,
  parameter int IW = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [IW-1:0]             waddr,
  input  logic [LANES-1:0]          wmask,
  input  logic [LANES-1:0][EW-1:0]  wdata,
  input  logic                      re,
  input  logic                      rclr,
  input  logic [IW-1:0]             raddr,
  output logic [LANES-1:0][EW-1:0]  rdata
);
  logic [LANES-1:0][EW-1:0] mem [DEPTH];
  // lane-masked write; the array itself is never reset, it is zero-filled by the controller
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (we && wmask[i]) mem[waddr][i] <= wdata[i];
  end
  // read register loads on an in-range read, zeroes on an out-of-range read, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
    else if (rclr) rdata <= '0;
  end
endmodule

// File: rtl/vec_data_mem_ctrl.sv
// vec_data_mem_ctrl: vector data memory controller with masked writes, registered reads and hardware clear
module vec_data_mem_ctrl
  import vec_mem_pkg::*;
#(
  parameter int LANES = LANES_D,
  parameter int EW = EW_D,
  parameter int DEPTH = DEPTH_D,
  parameter int AW = AW_D
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr_start,
  output logic                      busy,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [AW-1:0]             req_addr,
  input  logic [LANES-1:0]          req_wmask,
  input  logic [LANES-1:0][EW-1:0]  req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [LANES-1:0][EW-1:0]  rsp_rdata,
  output logic                      rsp_err
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  if (DEPTH > 2 ** AW) begin : g_aw_check
    $error("vec_data_mem_ctrl: AW too narrow for DEPTH");
  end
  state_t state, state_nx;
  logic [AW-1:0] clr_cnt, clr_nx;
  logic clr_last, in_range, acc, wr_acc, rd_acc;
  assign busy = state == CLEAR;
  assign clr_last = clr_cnt == AW'(DEPTH - 1);
  assign in_range = 32'(req_addr) < DEPTH;
  assign req_ready = state == RUN && !clr_start && (!rsp_valid || rsp_ready);
  assign acc = req_valid && req_ready;
  assign wr_acc = acc && req_we && in_range;
  assign rd_acc = acc && !req_we;
  // state and clear counter register; reset starts a fresh zero-fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nx;
      clr_cnt <= clr_nx;
    end
  end
  // clr_start always (re)starts the sweep at word 0; the sweep ends after word DEPTH-1
  always_comb begin
    state_nx = (clr_start || (state == CLEAR && !clr_last)) ? CLEAR : RUN;
    clr_nx = (clr_start || state == RUN || clr_last) ? '0 : clr_cnt + 1'b1;
  end
  // response channel: a new read loads, a taken response with no new read empties the slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
    end else if (rd_acc) begin
      rsp_valid <= 1'b1;
      rsp_err <= !in_range;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
  vec_mem_array #(.LANES(LANES), .EW(EW), .DEPTH(DEPTH), .IW(IW)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (busy || wr_acc),
    .waddr (busy ? clr_cnt[IW-1:0] : req_addr[IW-1:0]),
    .wmask (busy ? {LANES{1'b1}} : req_wmask),
    .wdata (busy ? '0 : req_wdata),
    .re    (rd_acc && in_range),
    .rclr  (rd_acc && !in_range),
    .raddr (req_addr[IW-1:0]),
    .rdata (rsp_rdata)
  );
endmodule

// File: tb/tb_vec_data_mem_ctrl.sv
// tb_vec_data_mem_ctrl: directed checks of clear, masked write, read response, range and backpressure behaviour
module tb_vec_data_mem_ctrl;
  localparam int DEPTH = 10927;
  logic clk, rst_n, clr_start, busy, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [16:0] req_addr;
  logic [5:0] req_wmask;
  logic [47:0] req_wdata, rsp_rdata;
  int n_tests = 0;
  int n_fail = 0;
  int n;
  logic bad;
  vec_data_mem_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_start (clr_start),
    .busy      (busy),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wmask (req_wmask),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input string tag, input logic we, input logic [16:0] a, input logic [5:0] m, input logic [47:0] d);
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_wmask = m;
    req_wdata = d;
    #1;
    chk({tag, "_ready"}, {47'd0, req_ready}, 48'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [16:0] a, input logic [47:0] d, input logic e);
    send(tag, 1'b0, a, 6'd0, 48'd0);
    chk({tag, "_valid"}, {47'd0, rsp_valid}, 48'd1);
    chk({tag, "_data"}, rsp_rdata, d);
    chk({tag, "_err"}, {47'd0, rsp_err}, {47'd0, e});
  endtask
  task automatic count_busy(output int cnt, output logic rdy_bad);
    cnt = 0;
    rdy_bad = 1'b0;
    while (busy === 1'b1 && cnt < 20000) begin
      if (req_ready !== 1'b0) rdy_bad = 1'b1;
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask
  initial begin
    rst_n = 1'b0;
    clr_start = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wmask = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {47'd0, busy}, 48'd1);
    chk("rst_rsp_valid", {47'd0, rsp_valid}, 48'd0);
    chk("rst_rdata", rsp_rdata, 48'd0);
    chk("rst_err", {47'd0, rsp_err}, 48'd0);
    chk("rst_ready", {47'd0, req_ready}, 48'd0);
    rst_n = 1'b1;
    count_busy(n, bad);
    chk("t1_busy_cycles", 48'(n), 48'(DEPTH));
    chk("t1_ready_low", {47'd0, bad}, 48'd0);
    rd("t1_rd123", 17'h00123, 48'd0, 1'b0);
    send("t2_wr", 1'b1, 17'd5, 6'b111111, 48'h060504030201);
    rd("t2_rd", 17'd5, 48'h060504030201, 1'b0);
    @(posedge clk);
    #1;
    chk("t2_valid_drop", {47'd0, rsp_valid}, 48'd0);
    send("t3_wr", 1'b1, 17'd5, 6'b000101, 48'hFFFFFFFFFFFF);
    rd("t3_rd", 17'd5, 48'h060504FF02FF, 1'b0);
    send("t3_wr6", 1'b1, 17'd6, 6'b111111, 48'hAABBCCDDEEFF);
    rd("t4_oor", 17'd10927, 48'd0, 1'b1);
    send("t4_wr_oor", 1'b1, 17'h1FFFF, 6'b111111, 48'h123456789ABC);
    rd("t4_rd_oor", 17'h1FFFF, 48'd0, 1'b1);
    rd("t4_rd5", 17'd5, 48'h060504FF02FF, 1'b0);
    send("t4_wr_last", 1'b1, 17'd10926, 6'b111111, 48'h0102A0B0C0D0);
    rd("t4_rd_last", 17'd10926, 48'h0102A0B0C0D0, 1'b0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    rd("t5_rd5", 17'd5, 48'h060504FF02FF, 1'b0);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 17'd6;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t5_hold_ready", {47'd0, req_ready}, 48'd0);
      chk("t5_hold_valid", {47'd0, rsp_valid}, 48'd1);
      chk("t5_hold_data", rsp_rdata, 48'h060504FF02FF);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    #1;
    chk("t5_release_ready", {47'd0, req_ready}, 48'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("t5_rd6_valid", {47'd0, rsp_valid}, 48'd1);
    chk("t5_rd6_data", rsp_rdata, 48'hAABBCCDDEEFF);
    @(posedge clk);
    #1;
    chk("t5_drop", {47'd0, rsp_valid}, 48'd0);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 17'd5;
    clr_start = 1'b1;
    #1;
    chk("t6_clr_ready", {47'd0, req_ready}, 48'd0);
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    req_valid = 1'b0;
    chk("t6_no_accept", {47'd0, rsp_valid}, 48'd0);
    count_busy(n, bad);
    chk("t6_busy_cycles", 48'(n), 48'(DEPTH));
    chk("t6_ready_low", {47'd0, bad}, 48'd0);
    rd("t6_rd5", 17'd5, 48'd0, 1'b0);
    rd("t6_rd6", 17'd6, 48'd0, 1'b0);
    send("t6_wr5", 1'b1, 17'd5, 6'b111111, 48'h5A5A5A5A5A5A);
    rsp_ready = 1'b0;
    rd("t6_rd5b", 17'd5, 48'h5A5A5A5A5A5A, 1'b0);
    clr_start = 1'b1;
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    chk("t6_busy2", {47'd0, busy}, 48'd1);
    chk("t6_pending", {47'd0, rsp_valid}, 48'd1);
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {47'd0, rsp_valid}, 48'd0);
    chk("t6_rst_busy", {47'd0, busy}, 48'd1);
    chk("t6_rst_rdata", rsp_rdata, 48'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    count_busy(n, bad);
    chk("t6_restart_cycles", 48'(n), 48'(DEPTH));
    rd("t6_rd5_final", 17'd5, 48'd0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
